asm_endereco_gravacao: RTL and testbench

- Write-side counterpart of the playback address ASM. Captures audio samples arriving at the 3 kHz sample rate and writes them to consecutive memory words from address 0.
- Drives the memory write handshake and handles record/pause and "rewind 10 s".
- Publishes the last written address, so playback knows where the recording ends.

---
 rtl/asm_endereco_gravacao_if.sv | 19 +
 rtl/asm_endereco_gravacao.sv | 210 +++++++++++++++++++++
 tb/tb_asm_endereco_gravacao.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/asm_endereco_gravacao_if.sv
// Memory write bus between the recording address ASM and the sample memory.
// Latency: none, wires only.
// Backpressure: the slave holds mem_ready low to stall a pending write.
//
// Ports (modports):
//   master - drives mem_we/mem_addr/mem_data and samples mem_ready (the ASM)
//   slave  - samples mem_we/mem_addr/mem_data and drives mem_ready (the memory)
interface asm_endereco_gravacao_if #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 8
);
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;

  modport master (output mem_we, output mem_addr, output mem_data, input mem_ready);
  modport slave  (input mem_we, input mem_addr, input mem_data, output mem_ready);
endinterface

// File: rtl/asm_endereco_gravacao.sv
// Recording address ASM: writes 3 kHz samples to consecutive words from address 0.
// Latency: strobe at cycle N gives mem_we at N+1 when the write side is idle.
// Backpressure: mem_ready low stalls the write; one sample is held, further ones dropped.
//
// Ports:
//   clk, reset        - clock and asynchronous active-high reset
//   grava, volta_10s  - record/pause and rewind-10 s buttons (act on release)
//   amostra_valida    - one-cycle strobe qualifying amostra
//   mem               - memory write bus (master side)
//   gravando, cheia   - main FSM in GRAVANDO / CHEIA
//   tem_gravacao      - at least one valid word recorded
//   ultimo_endereco   - address of the last valid word (0 when none)
//   perdidas          - dropped-sample count; built only with GRAVACAO_CONTA_PERDAS_EN
module asm_endereco_gravacao #(
  parameter int ADDR_W            = 22,
  parameter int DATA_W            = 8,
  parameter int ADDRS_POR_SEGUNDO = 3000,
  parameter int DEZ_SEGUNDOS      = 10 * ADDRS_POR_SEGUNDO
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   grava,
  input  logic                   volta_10s,
  input  logic                   amostra_valida,
  input  logic [DATA_W-1:0]      amostra,
  asm_endereco_gravacao_if.master mem,
  output logic                   gravando,
  output logic                   cheia,
  output logic                   tem_gravacao,
  output logic [ADDR_W-1:0]      ultimo_endereco,
  output logic [7:0]             perdidas
);

  localparam logic [1:0] INICIO   = 2'd0;
  localparam logic [1:0] GRAVANDO = 2'd1;
  localparam logic [1:0] PAUSADO  = 2'd2;
  localparam logic [1:0] CHEIA    = 2'd3;

  localparam logic [0:0] LIVRE      = 1'b0;
  localparam logic [0:0] ESCREVENDO = 1'b1;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W-1:0] DEZ      = ADDR_W'(DEZ_SEGUNDOS);
  localparam logic [ADDR_W-1:0] UM       = ADDR_W'(1);

  logic [1:0]        estado_q, estado_d;
  logic [0:0]        wst_q, wst_d;
  logic [ADDR_W-1:0] endereco_q, endereco_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              hold_vld_q, hold_vld_d;
  logic [DATA_W-1:0] hold_dat_q, hold_dat_d;
  logic              grava_prev_q, grava_prev_d;
  logic              volta_prev_q, volta_prev_d;
  logic              volta_pend_q, volta_pend_d;
  logic              tem_q, tem_d;
  logic [ADDR_W-1:0] ult_q, ult_d;

  logic              grava_rel, volta_rel;
  logic              escrevendo, completa, no_max, amostra_ok;
  logic              rew_req, rew_go;
  logic [ADDR_W-1:0] endereco_ef;

  assign grava_rel  = grava_prev_q & ~grava;
  assign volta_rel  = volta_prev_q & ~volta_10s;
  assign escrevendo = (wst_q == ESCREVENDO);
  assign completa   = escrevendo & mem.mem_ready;
  assign no_max     = (mem_addr_q == ADDR_MAX);
  assign amostra_ok = amostra_valida & (estado_q == GRAVANDO);
  // A rewind request survives until the write side is fully drained.
  assign rew_req    = (volta_rel | volta_pend_q) & (estado_q != INICIO);
  assign rew_go     = rew_req & ~escrevendo & ~hold_vld_q;

  always_comb begin
    estado_d     = estado_q;
    wst_d        = wst_q;
    endereco_d   = endereco_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    hold_vld_d   = hold_vld_q;
    hold_dat_d   = hold_dat_q;
    tem_d        = tem_q;
    ult_d        = ult_q;
    grava_prev_d = grava;
    volta_prev_d = volta_10s;
    volta_pend_d = rew_req & ~rew_go;
    endereco_ef  = endereco_q;

    // Main FSM; a simultaneous grava release loses to the rewind.
    if (rew_go) begin
      endereco_ef = (endereco_q >= DEZ) ? endereco_q - DEZ : '0;
      endereco_d  = endereco_ef;
      if (endereco_ef == '0) begin
        tem_d = 1'b0;
        ult_d = '0;
      end else begin
        ult_d = endereco_ef - UM;
      end
      if (estado_q == CHEIA) estado_d = PAUSADO;
    end else if (grava_rel & ~volta_rel) begin
      case (estado_q)
        INICIO:   estado_d = GRAVANDO;
        GRAVANDO: estado_d = PAUSADO;
        PAUSADO:  estado_d = GRAVANDO;
        default:  estado_d = estado_q;
      endcase
    end

    // Write FSM. A sample issued in the rewind cycle uses the rewound address.
    if (!escrevendo) begin
      if (amostra_ok) begin
        wst_d      = ESCREVENDO;
        mem_addr_d = endereco_ef;
        mem_data_d = amostra;
      end
    end else if (completa) begin
      tem_d = 1'b1;
      ult_d = mem_addr_q;
      if (no_max) begin
        // Memory full: no wrap, anything still queued is discarded.
        wst_d      = LIVRE;
        hold_vld_d = 1'b0;
        estado_d   = CHEIA;
      end else begin
        endereco_d = mem_addr_q + UM;
        if (hold_vld_q) begin
          mem_addr_d = mem_addr_q + UM;
          mem_data_d = hold_dat_q;
          hold_vld_d = amostra_ok;
          if (amostra_ok) hold_dat_d = amostra;
        end else if (amostra_ok) begin
          mem_addr_d = mem_addr_q + UM;
          mem_data_d = amostra;
        end else begin
          wst_d = LIVRE;
        end
      end
    end else if (amostra_ok && !hold_vld_q) begin
      hold_vld_d = 1'b1;
      hold_dat_d = amostra;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q     <= INICIO;
      wst_q        <= LIVRE;
      endereco_q   <= '0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      hold_vld_q   <= 1'b0;
      hold_dat_q   <= '0;
      grava_prev_q <= 1'b0;
      volta_prev_q <= 1'b0;
      volta_pend_q <= 1'b0;
      tem_q        <= 1'b0;
      ult_q        <= '0;
    end else begin
      estado_q     <= estado_d;
      wst_q        <= wst_d;
      endereco_q   <= endereco_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      hold_vld_q   <= hold_vld_d;
      hold_dat_q   <= hold_dat_d;
      grava_prev_q <= grava_prev_d;
      volta_prev_q <= volta_prev_d;
      volta_pend_q <= volta_pend_d;
      tem_q        <= tem_d;
      ult_q        <= ult_d;
    end
  end

`ifdef GRAVACAO_CONTA_PERDAS_EN
  logic [7:0] perdidas_q, perdidas_d;
  logic [1:0] drop_cnt;
  logic [8:0] soma;

  always_comb begin
    drop_cnt = 2'd0;
    if (completa && no_max)
      drop_cnt = {1'b0, hold_vld_q} + {1'b0, amostra_ok};
    else if (escrevendo && !completa && amostra_ok && hold_vld_q)
      drop_cnt = 2'd1;
    soma = {1'b0, perdidas_q} + {7'd0, drop_cnt};
    if (grava_rel && !volta_rel && estado_q == INICIO)
      perdidas_d = 8'd0;
    else
      perdidas_d = soma[8] ? 8'hFF : soma[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) perdidas_q <= 8'd0;
    else       perdidas_q <= perdidas_d;
  end

  assign perdidas = perdidas_q;
`else
  assign perdidas = 8'd0;
`endif

  assign mem.mem_we      = (wst_q == ESCREVENDO);
  assign mem.mem_addr    = mem_addr_q;
  assign mem.mem_data    = mem_data_q;
  assign gravando        = (estado_q == GRAVANDO);
  assign cheia           = (estado_q == CHEIA);
  assign tem_gravacao    = tem_q;
  assign ultimo_endereco = ult_q;

endmodule

// File: tb/tb_asm_endereco_gravacao.sv
module tb_asm_endereco_gravacao;

`ifdef GRAVACAO_CONTA_PERDAS_EN
  localparam int PERD_EXP = 1;
`else
  localparam int PERD_EXP = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       grava = 1'b0;
  logic       volta_10s = 1'b0;
  logic       amostra_valida = 1'b0;
  logic [7:0] amostra = 8'd0;
  logic       mem_ready = 1'b1;

  int checks = 0;
  int failures = 0;

  // Full-size instance.
  asm_endereco_gravacao_if #(.ADDR_W(22), .DATA_W(8)) m_if ();
  logic        m_grav, m_cheia, m_tem;
  logic [21:0] m_ult;
  logic [7:0]  m_perd;
  assign m_if.mem_ready = mem_ready;

  asm_endereco_gravacao #(.ADDR_W(22), .DATA_W(8), .ADDRS_POR_SEGUNDO(3000)) dut (
    .clk(clk), .reset(reset), .grava(grava), .volta_10s(volta_10s),
    .amostra_valida(amostra_valida), .amostra(amostra), .mem(m_if),
    .gravando(m_grav), .cheia(m_cheia), .tem_gravacao(m_tem),
    .ultimo_endereco(m_ult), .perdidas(m_perd)
  );

  // Small instance (8-bit address, 100-word rewind) to reach the full boundary quickly.
  asm_endereco_gravacao_if #(.ADDR_W(8), .DATA_W(8)) s_if ();
  logic       s_grav, s_cheia, s_tem;
  logic [7:0] s_ult;
  logic [7:0] s_perd;
  assign s_if.mem_ready = mem_ready;

  asm_endereco_gravacao #(.ADDR_W(8), .DATA_W(8), .ADDRS_POR_SEGUNDO(10)) dut_s (
    .clk(clk), .reset(reset), .grava(grava), .volta_10s(volta_10s),
    .amostra_valida(amostra_valida), .amostra(amostra), .mem(s_if),
    .gravando(s_grav), .cheia(s_cheia), .tem_gravacao(s_tem),
    .ultimo_endereco(s_ult), .perdidas(s_perd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic press_grava();
    grava = 1'b1;
    tick();
    grava = 1'b0;
    tick();
  endtask

  task automatic press_volta();
    volta_10s = 1'b1;
    tick();
    volta_10s = 1'b0;
    tick();
  endtask

  // Pulse one strobe; after return the write (if idle) is on the bus.
  task automatic strobe(input logic [7:0] v);
    amostra_valida = 1'b1;
    amostra = v;
    tick();
    amostra_valida = 1'b0;
  endtask

  // n back-to-back strobes, then one idle cycle so the last write completes.
  task automatic record(input int n);
    for (int i = 0; i < n; i++) begin
      amostra_valida = 1'b1;
      amostra = 8'(i);
      tick();
    end
    amostra_valida = 1'b0;
    tick();
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_we", m_if.mem_we, 0);
    check("rst_addr", m_if.mem_addr, 0);
    check("rst_data", m_if.mem_data, 0);
    check("rst_grav", m_grav, 0);
    check("rst_cheia", m_cheia, 0);
    check("rst_tem", m_tem, 0);
    check("rst_ult", m_ult, 0);
    check("rst_perd", m_perd, 0);

    // Three writes with mem_ready always high
    press_grava();
    check("grav_on", m_grav, 1);
    strobe(8'h11);
    check("w0_we", m_if.mem_we, 1);
    check("w0_addr", m_if.mem_addr, 0);
    check("w0_data", m_if.mem_data, 8'h11);
    tick();
    check("w0_done_we", m_if.mem_we, 0);
    check("w0_ult", m_ult, 0);
    strobe(8'h22);
    check("w1_addr", m_if.mem_addr, 1);
    check("w1_data", m_if.mem_data, 8'h22);
    tick();
    strobe(8'h33);
    check("w2_addr", m_if.mem_addr, 2);
    check("w2_data", m_if.mem_data, 8'h33);
    tick();
    check("w2_ult", m_ult, 2);
    check("w2_tem", m_tem, 1);
    check("w2_grav", m_grav, 1);

    // Stall: first sample in flight, second held, third dropped
    mem_ready = 1'b0;
    strobe(8'h44);
    check("st_we", m_if.mem_we, 1);
    check("st_addr0", m_if.mem_addr, 3);
    strobe(8'h55);
    check("st_addr1", m_if.mem_addr, 3);
    strobe(8'h66);
    check("st_data2", m_if.mem_data, 8'h44);
    tick();
    tick();
    check("st_addr4", m_if.mem_addr, 3);
    check("st_data4", m_if.mem_data, 8'h44);
    check("st_we4", m_if.mem_we, 1);
    check("st_perd", m_perd, PERD_EXP);
    mem_ready = 1'b1;
    tick();
    check("b2b_we", m_if.mem_we, 1);
    check("b2b_addr", m_if.mem_addr, 4);
    check("b2b_data", m_if.mem_data, 8'h55);
    check("b2b_ult", m_ult, 3);
    tick();
    check("b2b_done_we", m_if.mem_we, 0);
    check("b2b_ult2", m_ult, 4);

    // grava and volta released together: rewind (5 -> 0) wins, still recording
    grava = 1'b1;
    volta_10s = 1'b1;
    tick();
    grava = 1'b0;
    volta_10s = 1'b0;
    tick();
    check("both_grav", m_grav, 1);
    check("both_tem", m_tem, 0);
    check("both_ult", m_ult, 0);

    // 35000 samples, rewind -> 5000
    do_reset();
    press_grava();
    record(35000);
    check("r35k_ult", m_ult, 34999);
    press_volta();
    check("r35k_rew_ult", m_ult, 4999);
    check("r35k_rew_tem", m_tem, 1);
    check("r35k_rew_grav", m_grav, 1);
    strobe(8'hA5);
    check("r35k_next_addr", m_if.mem_addr, 5000);
    tick();

    // 4000 samples, rewind -> 0
    do_reset();
    press_grava();
    record(4000);
    check("r4k_ult", m_ult, 3999);
    press_volta();
    check("r4k_rew_tem", m_tem, 0);
    check("r4k_rew_ult", m_ult, 0);
    strobe(8'h5A);
    check("r4k_next_addr", m_if.mem_addr, 0);
    tick();

    // Fill the small instance to its last address (0xFF)
    do_reset();
    press_grava();
    record(256);
    check("full_cheia", s_cheia, 1);
    check("full_grav", s_grav, 0);
    check("full_ult", s_ult, 8'hFF);
    check("full_we", s_if.mem_we, 0);
    strobe(8'h77);
    check("full_ign_we", s_if.mem_we, 0);
    tick();
    check("full_ign_ult", s_ult, 8'hFF);
    check("full_perd", s_perd, 0);
    press_grava();
    check("full_grava_ign", s_cheia, 1);
    press_volta();
    check("full_rew_cheia", s_cheia, 0);
    check("full_rew_grav", s_grav, 0);
    check("full_rew_ult", s_ult, 8'd154);
    press_grava();
    check("full_resume_grav", s_grav, 1);
    strobe(8'h99);
    check("full_resume_addr", s_if.mem_addr, 8'd155);

    // Asynchronous reset while a write is pending
    do_reset();
    press_grava();
    mem_ready = 1'b0;
    strobe(8'hC3);
    check("ar_we_before", m_if.mem_we, 1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_we", m_if.mem_we, 0);
    check("ar_addr", m_if.mem_addr, 0);
    check("ar_data", m_if.mem_data, 0);
    check("ar_grav", m_grav, 0);
    check("ar_tem", m_tem, 0);
    check("ar_ult", m_ult, 0);
    check("ar_perd", m_perd, 0);
    tick();
    reset = 1'b0;
    mem_ready = 1'b1;
    tick();
    check("ar_after_we", m_if.mem_we, 0);
    check("ar_after_grav", m_grav, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
